// File: rtl/sd_blk_seq_if.sv
// Register-port bundle around sd_blk_seq: FPGA block requests, spi_link_sm pass-through and sdc_controller bus.
// master = requester/SPI/controller side, slave = the sequencer.
interface sd_blk_seq_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_lba;
  logic        req_ready;
  logic        done;
  logic [1:0]  err;
  logic        fpga_mode;
  logic [6:0]  spi_addr;
  logic        spi_we;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic        spi_dropped;
  logic [6:0]  sd_addr;
  logic        sd_we;
  logic [7:0]  sd_wdata;
  logic [7:0]  sd_rdata;

  modport master (
    output req_valid, req_write, req_lba, spi_addr, spi_we, spi_wdata, sd_rdata,
    input  req_ready, done, err, fpga_mode, spi_rdata, spi_dropped, sd_addr, sd_we, sd_wdata
  );

  modport slave (
    input  req_valid, req_write, req_lba, spi_addr, spi_we, spi_wdata, sd_rdata,
    output req_ready, done, err, fpga_mode, spi_rdata, spi_dropped, sd_addr, sd_we, sd_wdata
  );
endinterface

// File: rtl/sd_blk_seq.sv
// Single-block CMD17/CMD24 sequencer owning the sdc_controller register bus; accept->done >= 14 cycles.
// One request at a time: req_ready only in IDLE, SPI writes made while busy are dropped and flagged.
module sd_blk_seq #(
  parameter logic [6:0] EVT_ADDR  = 7'h3C,
  parameter logic [7:0] DONE_MASK = 8'h01,
  parameter logic [7:0] ERR_MASK  = 8'h1E,
  parameter int         POLL_GAP  = 16,
  parameter int         TIMEOUT   = 2**20
) (
  input  logic        clk,
  input  logic        rstn_async,
  sd_blk_seq_if.slave bus
);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_POLL_A, S_POLL_C, S_WAIT, S_CLR, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic          r_write;
  logic [31:0]   r_lba;
  logic [3:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic [TW-1:0] r_tmo;
  logic [1:0]    r_err, w_err_nxt;
  logic          r_drop;
  logic          w_accept, w_tmo, w_polling;
  logic [6:0]    w_cfg_addr;
  logic [7:0]    w_cfg_data;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_polling = (r_state == S_POLL_A) || (r_state == S_POLL_C) || (r_state == S_WAIT);
  assign w_tmo     = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_err_nxt = r_err;
    case (r_state)
      S_IDLE: begin
        w_err_nxt = 2'd0;
        if (bus.req_valid) w_next = S_CFG;
      end
      S_CFG:    if (r_idx == 4'd8) w_next = S_POLL_A;
      S_POLL_A: begin
        if (w_tmo) begin
          w_next    = S_CLR;
          w_err_nxt = 2'd2;
        end else begin
          w_next = S_POLL_C;
        end
      end
      // Error bits take priority over the done bit in the same status read.
      S_POLL_C: begin
        if ((bus.sd_rdata & ERR_MASK) != 8'h00) begin
          w_next    = S_CLR;
          w_err_nxt = 2'd1;
        end else if ((bus.sd_rdata & DONE_MASK) != 8'h00) begin
          w_next    = S_CLR;
          w_err_nxt = 2'd0;
        end else if (w_tmo) begin
          w_next    = S_CLR;
          w_err_nxt = 2'd2;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_tmo) begin
          w_next    = S_CLR;
          w_err_nxt = 2'd2;
        end else if (r_gap == GW'(POLL_GAP - 1)) begin
          w_next = S_POLL_A;
        end
      end
      S_CLR:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      r_write <= 1'b0;
      r_lba   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_tmo   <= '0;
      r_err   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_err  <= w_err_nxt;
      r_drop <= (r_state != S_IDLE) && bus.spi_we;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_lba   <= bus.req_lba;
      end
      r_idx <= (r_state == S_CFG)  ? r_idx + 4'd1 : 4'd0;
      r_gap <= (r_state == S_WAIT) ? r_gap + 1'b1 : '0;
      r_tmo <= w_polling           ? r_tmo + 1'b1 : '0;
    end
  end

  // Register programming order; the final write to 0x00 launches the command.
  always_comb begin
    w_cfg_addr = 7'h00;
    w_cfg_data = 8'h00;
    case (r_idx)
      4'd0: begin w_cfg_addr = 7'h48; w_cfg_data = 8'h00; end
      4'd1: begin w_cfg_addr = 7'h44; w_cfg_data = 8'hFF; end
      4'd2: begin w_cfg_addr = 7'h45; w_cfg_data = 8'h01; end
      4'd3: begin w_cfg_addr = 7'h05; w_cfg_data = r_write ? 8'd24 : 8'd17; end
      4'd4: begin w_cfg_addr = 7'h04; w_cfg_data = r_write ? 8'h80 : 8'h5D; end
      4'd5: begin w_cfg_addr = 7'h03; w_cfg_data = r_lba[31:24]; end
      4'd6: begin w_cfg_addr = 7'h02; w_cfg_data = r_lba[23:16]; end
      4'd7: begin w_cfg_addr = 7'h01; w_cfg_data = r_lba[15:8]; end
      4'd8: begin w_cfg_addr = 7'h00; w_cfg_data = r_lba[7:0]; end
      default: begin w_cfg_addr = 7'h00; w_cfg_data = 8'h00; end
    endcase
  end

  always_comb begin
    bus.req_ready   = (r_state == S_IDLE);
    bus.done        = (r_state == S_DONE);
    bus.err         = (r_state == S_DONE) ? r_err : 2'd0;
    bus.fpga_mode   = (r_state != S_IDLE) && (r_state != S_DONE);
    bus.spi_rdata   = bus.sd_rdata;
    bus.spi_dropped = r_drop;
    bus.sd_addr     = 7'h00;
    bus.sd_we       = 1'b0;
    bus.sd_wdata    = 8'h00;
    case (r_state)
      S_IDLE: begin
        bus.sd_addr  = bus.spi_addr;
        bus.sd_we    = bus.spi_we;
        bus.sd_wdata = bus.spi_wdata;
      end
      S_CFG: begin
        bus.sd_addr  = w_cfg_addr;
        bus.sd_we    = 1'b1;
        bus.sd_wdata = w_cfg_data;
      end
      S_POLL_A, S_POLL_C: bus.sd_addr = EVT_ADDR;
      S_CLR: begin
        bus.sd_addr  = EVT_ADDR;
        bus.sd_we    = 1'b1;
        bus.sd_wdata = 8'h00;
      end
      default: ;
    endcase
  end
endmodule
